// File: rtl/nanorv32_busarb_pkg.sv
// Shared widths and FSM state encodings for the nanorv32 code/data bus arbiter.
package nanorv32_busarb_pkg;

    localparam int NANORV32_ADDR_MSB = 31;
    localparam int NANORV32_DATA_MSB = 31;

    typedef enum logic [1:0] {
        NANORV32_BUSARB_STATE_IDLE     = 2'd0,
        NANORV32_BUSARB_STATE_GNT_CODE = 2'd1,
        NANORV32_BUSARB_STATE_GNT_DATA = 2'd2
    } busarb_state_t;

endpackage

// File: rtl/nanorv32_busarb_if.sv
// Bundle of CPU fetch port, CPU data port and shared memory port around the arbiter.
interface nanorv32_busarb_if;
    import nanorv32_busarb_pkg::*;

    logic [NANORV32_ADDR_MSB:0] cpu_codemem_addr;
    logic                       cpu_codemem_req;
    logic [NANORV32_DATA_MSB:0] codemem_cpu_rdata;
    logic                       codemem_cpu_ack;

    logic [NANORV32_ADDR_MSB:0] cpu_datamem_addr;
    logic [NANORV32_DATA_MSB:0] cpu_datamem_wdata;
    logic [3:0]                 cpu_datamem_bytesel;
    logic                       cpu_datamem_write;
    logic                       cpu_datamem_req;
    logic [NANORV32_DATA_MSB:0] datamem_cpu_rdata;
    logic                       datamem_cpu_ack;

    logic [NANORV32_ADDR_MSB:0] mem_addr;
    logic [NANORV32_DATA_MSB:0] mem_wdata;
    logic [3:0]                 mem_bytesel;
    logic                       mem_write;
    logic                       mem_req;
    logic [NANORV32_DATA_MSB:0] mem_rdata;
    logic                       mem_ack;

    // The arbiter's own view of the bundle.
    modport slave (
        input  cpu_codemem_addr, cpu_codemem_req,
        output codemem_cpu_rdata, codemem_cpu_ack,
        input  cpu_datamem_addr, cpu_datamem_wdata, cpu_datamem_bytesel,
        input  cpu_datamem_write, cpu_datamem_req,
        output datamem_cpu_rdata, datamem_cpu_ack,
        output mem_addr, mem_wdata, mem_bytesel, mem_write, mem_req,
        input  mem_rdata, mem_ack
    );

    modport master (
        output cpu_codemem_addr, cpu_codemem_req,
        input  codemem_cpu_rdata, codemem_cpu_ack,
        output cpu_datamem_addr, cpu_datamem_wdata, cpu_datamem_bytesel,
        output cpu_datamem_write, cpu_datamem_req,
        input  datamem_cpu_rdata, datamem_cpu_ack,
        input  mem_addr, mem_wdata, mem_bytesel, mem_write, mem_req,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/nanorv32_busarb.sv
// Arbitrates CPU fetch and data accesses onto one memory port, one access at a time,
// data first from idle, alternating when both wait, with a per-access ack timeout.
module nanorv32_busarb
    import nanorv32_busarb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    nanorv32_busarb_if.slave    bus,
    output logic                bus_err
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    busarb_state_t state, state_nxt;
    logic [7:0]    wait_cnt;
    logic          timeout;
    logic          done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= NANORV32_BUSARB_STATE_IDLE;
            wait_cnt <= 8'd0;
            bus_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            // Every completion starts a fresh grant (or idles), so the count restarts.
            if (state == NANORV32_BUSARB_STATE_IDLE || done)
                wait_cnt <= 8'd0;
            else
                wait_cnt <= wait_cnt + 8'd1;
            if (timeout)
                bus_err <= 1'b1;
        end
    end

    always_comb begin
        state_nxt             = state;
        timeout               = 1'b0;
        done                  = 1'b0;
        bus.mem_req           = 1'b0;
        bus.mem_addr          = '0;
        bus.mem_wdata         = '0;
        bus.mem_bytesel       = 4'h0;
        bus.mem_write         = 1'b0;
        bus.codemem_cpu_ack   = 1'b0;
        bus.datamem_cpu_ack   = 1'b0;
        bus.codemem_cpu_rdata = '0;
        bus.datamem_cpu_rdata = '0;

        if (state != NANORV32_BUSARB_STATE_IDLE) begin
            timeout = !bus.mem_ack && (wait_cnt == TIMEOUT_LAST);
            done    = bus.mem_ack || timeout;
            bus.mem_req = 1'b1;
            if (!timeout) begin
                bus.codemem_cpu_rdata = bus.mem_rdata;
                bus.datamem_cpu_rdata = bus.mem_rdata;
            end
        end

        case (state)
            NANORV32_BUSARB_STATE_IDLE: begin
                if (bus.cpu_datamem_req)
                    state_nxt = NANORV32_BUSARB_STATE_GNT_DATA;
                else if (bus.cpu_codemem_req)
                    state_nxt = NANORV32_BUSARB_STATE_GNT_CODE;
            end
            NANORV32_BUSARB_STATE_GNT_CODE: begin
                bus.mem_addr        = bus.cpu_codemem_addr;
                bus.mem_bytesel     = 4'hF;
                bus.codemem_cpu_ack = done;
                // Hand the bus to the other requester first so neither can starve.
                if (done) begin
                    if (bus.cpu_datamem_req)
                        state_nxt = NANORV32_BUSARB_STATE_GNT_DATA;
                    else if (bus.cpu_codemem_req)
                        state_nxt = NANORV32_BUSARB_STATE_GNT_CODE;
                    else
                        state_nxt = NANORV32_BUSARB_STATE_IDLE;
                end
            end
            NANORV32_BUSARB_STATE_GNT_DATA: begin
                bus.mem_addr        = bus.cpu_datamem_addr;
                bus.mem_wdata       = bus.cpu_datamem_wdata;
                bus.mem_bytesel     = bus.cpu_datamem_bytesel;
                bus.mem_write       = bus.cpu_datamem_write;
                bus.datamem_cpu_ack = done;
                if (done) begin
                    if (bus.cpu_codemem_req)
                        state_nxt = NANORV32_BUSARB_STATE_GNT_CODE;
                    else if (bus.cpu_datamem_req)
                        state_nxt = NANORV32_BUSARB_STATE_GNT_DATA;
                    else
                        state_nxt = NANORV32_BUSARB_STATE_IDLE;
                end
            end
            default: state_nxt = NANORV32_BUSARB_STATE_IDLE;
        endcase
    end

endmodule

// File: tb/tb_nanorv32_busarb.sv
// Directed bench for nanorv32_busarb: arbitration order, store routing, timeout and reset abort.
module tb_nanorv32_busarb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bus_err;
    int   checkCount = 0;
    int   errCount = 0;

    nanorv32_busarb_if bus ();

    nanorv32_busarb #(.TIMEOUT_CYCLES(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .bus_err (bus_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One bench cycle: drive at the falling edge, let comb logic settle, then caller checks.
    task automatic applyStimulus(input logic codeReq, input logic dataReq,
                                 input logic memAck, input logic [31:0] memRdata);
        @(negedge clk);
        bus.cpu_codemem_req = codeReq;
        bus.cpu_datamem_req = dataReq;
        bus.mem_ack         = memAck;
        bus.mem_rdata       = memRdata;
        #1;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n               = 1'b0;
        bus.cpu_codemem_req = 1'b0;
        bus.cpu_datamem_req = 1'b0;
        bus.mem_ack         = 1'b1;
        bus.mem_rdata       = 32'hA5A5_A5A5;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        checkOutput("rst_code_ack", {31'd0, bus.codemem_cpu_ack}, 32'd0);
        checkOutput("rst_data_ack", {31'd0, bus.datamem_cpu_ack}, 32'd0);
        checkOutput("rst_bus_err", {31'd0, bus_err}, 32'd0);
        checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", bus.mem_wdata, 32'd0);
        checkOutput("rst_mem_ctl", {27'd0, bus.mem_bytesel, bus.mem_write}, 32'd0);
        checkOutput("rst_code_rdata", bus.codemem_cpu_rdata, 32'd0);
        checkOutput("rst_data_rdata", bus.datamem_cpu_rdata, 32'd0);
        bus.mem_ack = 1'b0;
        rst_n       = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] grantAddr [5];
        bus.cpu_codemem_addr    = 32'h0;
        bus.cpu_datamem_addr    = 32'h0;
        bus.cpu_datamem_wdata   = 32'h0;
        bus.cpu_datamem_bytesel = 4'h0;
        bus.cpu_datamem_write   = 1'b0;
        bus.cpu_codemem_req     = 1'b0;
        bus.cpu_datamem_req     = 1'b0;
        bus.mem_ack             = 1'b0;
        bus.mem_rdata           = 32'h0;
        resetDut();

        $display("[TB] fetch with ack two cycles after request");
        bus.cpu_codemem_addr  = 32'h40;
        bus.cpu_datamem_wdata = 32'h1111_1111;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("fetch_idle_req", {31'd0, bus.mem_req}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("fetch_gnt_req", {31'd0, bus.mem_req}, 32'd1);
        checkOutput("fetch_addr", bus.mem_addr, 32'h40);
        checkOutput("fetch_ctl", {27'd0, bus.mem_bytesel, bus.mem_write}, 32'h1E);
        checkOutput("fetch_wdata", bus.mem_wdata, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("fetch_wait_ack", {31'd0, bus.codemem_cpu_ack}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0013);
        checkOutput("fetch_ack", {31'd0, bus.codemem_cpu_ack}, 32'd1);
        checkOutput("fetch_rdata", bus.codemem_cpu_rdata, 32'h13);
        checkOutput("fetch_no_data_ack", {31'd0, bus.datamem_cpu_ack}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h99);
        checkOutput("fetch_back_idle", {31'd0, bus.mem_req}, 32'd0);
        checkOutput("idle_ack_ignored", {30'd0, bus.codemem_cpu_ack, bus.datamem_cpu_ack}, 32'd0);

        $display("[TB] both requesters, ack every cycle");
        resetDut();
        bus.cpu_codemem_addr = 32'h200;
        bus.cpu_datamem_addr = 32'h300;
        grantAddr = '{32'h300, 32'h200, 32'h300, 32'h200, 32'h300};
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h5);
        checkOutput("both_idle_req", {31'd0, bus.mem_req}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(i < 3, i < 4, 1'b1, 32'h5);
            checkOutput("both_req", {31'd0, bus.mem_req}, 32'd1);
            checkOutput("both_addr", bus.mem_addr, grantAddr[i]);
            checkOutput("both_acks", {30'd0, bus.codemem_cpu_ack, bus.datamem_cpu_ack},
                        (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("both_end_idle", {31'd0, bus.mem_req}, 32'd0);

        $display("[TB] data store routing");
        bus.cpu_datamem_addr    = 32'h100;
        bus.cpu_datamem_wdata   = 32'hDEAD_BEEF;
        bus.cpu_datamem_bytesel = 4'h3;
        bus.cpu_datamem_write   = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            checkOutput("store_addr", bus.mem_addr, 32'h100);
            checkOutput("store_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
            checkOutput("store_ctl", {27'd0, bus.mem_bytesel, bus.mem_write}, 32'h7);
            checkOutput("store_wait_ack", {31'd0, bus.datamem_cpu_ack}, 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
        checkOutput("store_ack", {31'd0, bus.datamem_cpu_ack}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("store_idle_write", {30'd0, bus.mem_req, bus.mem_write}, 32'd0);
        bus.cpu_datamem_write = 1'b0;

        $display("[TB] ack arrives on the timeout cycle");
        bus.cpu_datamem_addr = 32'h180;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("late_wait_ack", {31'd0, bus.datamem_cpu_ack}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hCAFE_0001);
        checkOutput("late_ack", {31'd0, bus.datamem_cpu_ack}, 32'd1);
        checkOutput("late_rdata", bus.datamem_cpu_rdata, 32'hCAFE_0001);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("late_no_err", {31'd0, bus_err}, 32'd0);

        $display("[TB] fetch that never gets an ack");
        bus.cpu_codemem_addr = 32'h80;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h1234_5678);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h1234_5678);
        checkOutput("to_wait_ack", {31'd0, bus.codemem_cpu_ack}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h1234_5678);
        checkOutput("to_ack", {31'd0, bus.codemem_cpu_ack}, 32'd1);
        checkOutput("to_rdata", bus.codemem_cpu_rdata, 32'd0);
        checkOutput("to_no_data_ack", {31'd0, bus.datamem_cpu_ack}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("to_req_drop", {31'd0, bus.mem_req}, 32'd0);
        checkOutput("to_err_set", {31'd0, bus_err}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
        checkOutput("to_err_sticky", {31'd0, bus_err}, 32'd1);

        $display("[TB] reset during a data grant");
        resetDut();
        bus.cpu_datamem_addr = 32'h300;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("abort_gnt_req", {31'd0, bus.mem_req}, 32'd1);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h77);
        checkOutput("abort_no_ack", {31'd0, bus.datamem_cpu_ack}, 32'd0);
        checkOutput("abort_req_low", {31'd0, bus.mem_req}, 32'd0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("abort_idle", {31'd0, bus.mem_req}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/nanorv32_busarb.md
NANORV32_BUSARB -- requirements
Module: nanorv32_busarb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, cycles a granted access may wait for mem_ack (legal 1..255).
REQ-002 SHALL have port clk  input  1  the single clock; all logic rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port cpu_codemem_addr  input  NANORV32_ADDR_MSB+1  instruction fetch address.
REQ-005 SHALL have port cpu_codemem_req  input  1  fetch request, held until codemem_cpu_ack.
REQ-006 SHALL have port codemem_cpu_rdata  output  NANORV32_DATA_MSB+1  fetch read data.
REQ-007 SHALL have port codemem_cpu_ack  output  1  fetch completion, one cycle.
REQ-008 SHALL have port cpu_datamem_addr  input  NANORV32_ADDR_MSB+1  data access address.
REQ-009 SHALL have port cpu_datamem_wdata  input  NANORV32_DATA_MSB+1  store data.
REQ-010 SHALL have port cpu_datamem_bytesel  input  4  byte lane enables.
REQ-011 SHALL have port cpu_datamem_write  input  1  1 = store, 0 = load.
REQ-012 SHALL have port cpu_datamem_req  input  1  data request, held until datamem_cpu_ack.
REQ-013 SHALL have port datamem_cpu_rdata  output  NANORV32_DATA_MSB+1  load read data.
REQ-014 SHALL have port datamem_cpu_ack  output  1  data completion, one cycle.
REQ-015 SHALL have port mem_addr / mem_wdata / mem_bytesel / mem_write  output  ADDR/DATA/4/1  shared memory command.
REQ-016 SHALL have port mem_req  output  1  shared memory request.
REQ-017 SHALL have port mem_rdata  input  NANORV32_DATA_MSB+1 and mem_ack  input  1  memory response.
REQ-018 SHALL have port bus_err  output  1  sticky timeout flag.

Function
REQ-019 SHALL implement FSM states IDLE, GNT_CODE, GNT_DATA; exactly one access outstanding.
REQ-020 In IDLE with any req high SHALL enter a grant state next cycle (one-cycle arbitration latency); mem_req=0 in IDLE.
REQ-021 Both requests in IDLE: SHALL grant data first.
REQ-022 In GNT_x SHALL drive mem_req=1 and mem_* from requester x; code grants drive mem_write=0, mem_bytesel=4'hF, mem_wdata=0.
REQ-023 mem_ack in GNT_x SHALL pass combinationally to x's ack, same cycle; mem_rdata SHALL be routed to both rdata outputs.
REQ-024 On ack cycle next state SHALL be: other requester's grant if its req high; else same grant if own req still high; else IDLE (back-to-back, no idle bubble).
REQ-025 Consecutive completions with both requesting SHALL alternate code/data (no starvation).
REQ-026 8-bit wait counter SHALL clear on grant entry, increment each GNT cycle without mem_ack.
REQ-027 Counter reaching TIMEOUT_CYCLES without mem_ack SHALL, that cycle, pulse owner's ack with rdata forced 0, drop mem_req next cycle, set bus_err, and re-arbitrate per REQ-024.
REQ-028 mem_ack on the timeout cycle SHALL win: normal completion, no bus_err.
REQ-029 mem_ack in IDLE SHALL be ignored; no ack output.
REQ-030 bus_err SHALL stay 1 until reset.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force IDLE, counter 0, bus_err 0; mem_req, both acks 0 from the next cycle, including mid-access (in-flight access abandoned, late mem_ack ignored).
REQ-032 Reset values: mem_addr/wdata/bytesel/write 0, rdata outputs 0.

Structure
REQ-033 FSM state encodings NANORV32_BUSARB_STATE_* SHALL live in the shared nanorv32_parameters.v; widths reuse NANORV32_ADDR_MSB/NANORV32_DATA_MSB.
REQ-034 SHALL be one flat module; no sub-module.

Verification
REQ-035 Code req only, mem_ack 2 cycles after mem_req, rdata 32'h00000013 -> codemem_cpu_ack pulse with that data, return IDLE.
REQ-036 Both req high from reset, mem_ack every cycle -> grant order D,C,D,C; mem_req continuously 1.
REQ-037 Data store addr 32'h100, wdata 32'hDEADBEEF, bytesel 4'h3 -> mem_write=1 with identical addr/wdata/bytesel until ack.
REQ-038 TIMEOUT_CYCLES=4, mem_ack never -> owner ack on 4th wait cycle, rdata 0, bus_err=1, persists.
REQ-039 rst_n low during GNT_DATA, mem_ack pulsed next cycle -> no datamem_cpu_ack, state IDLE.
REQ-040 mem_ack exactly on timeout cycle -> normal completion, bus_err stays 0.
